// File: rtl/periph_bus_ctrl.sv
// Peripheral bus controller: decodes a word address into port/register, owns the
// register storage and runs each access through request/response handshakes with wait states.
module periph_bus_ctrl #(
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 32,
  parameter int NUM_PORTS     = 4,
  parameter int REGS_PER_PORT = 4,
  parameter int WAIT_CYCLES   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic                 req_write,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [DATA_W-1:0]    req_wdata,
  output logic                 req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_W-1:0]    rsp_rdata,
  output logic                 rsp_err,
  output logic [NUM_PORTS-1:0] port_sel,
  output logic [NUM_PORTS-1:0] port_wr
);

  localparam int PSEL_W = $clog2(NUM_PORTS);
  localparam int RSEL_W = $clog2(REGS_PER_PORT);
  localparam int RI_W   = (RSEL_W > 0) ? RSEL_W : 1;

  // Handshakes: a request transfers on an edge where req_valid && req_ready;
  // a response transfers on an edge where rsp_valid && rsp_ready. Once raised,
  // rsp_valid/rsp_rdata/rsp_err hold until that transfer.
  typedef enum logic [1:0] {IDLE, WAIT, COMMIT, RESP} state_t;

  state_t state, state_next;

  logic [DATA_W-1:0] regs [NUM_PORTS][REGS_PER_PORT];

  logic              lat_write;
  logic [PSEL_W-1:0] lat_port;
  logic [RI_W-1:0]   lat_reg;
  logic [DATA_W-1:0] lat_wdata;
  logic              lat_err;
  logic [3:0]        wait_cnt;

  logic [PSEL_W-1:0] dec_port;
  logic [RI_W-1:0]   dec_reg;
  logic              dec_unmapped;
  logic              dec_err;

  assign dec_port = req_addr[ADDR_W-1 -: PSEL_W];

  generate
    if (RSEL_W > 0) begin : g_reg
      assign dec_reg = req_addr[RSEL_W+1:2];
    end else begin : g_noreg
      assign dec_reg = '0;
    end
  endgenerate

  // Any set bit in the gap between the register field and the port field is unmapped.
  always_comb begin
    dec_unmapped = 1'b0;
    for (int i = RSEL_W + 2; i < ADDR_W - PSEL_W; i++) begin
      dec_unmapped = dec_unmapped | req_addr[i];
    end
  end

  assign dec_err = (|req_addr[1:0]) | dec_unmapped;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    port_wr    = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = (WAIT_CYCLES > 0) ? WAIT : COMMIT;
      end
      WAIT:   if (wait_cnt == 4'd0) state_next = COMMIT;
      COMMIT: begin
        state_next = RESP;
        if (lat_write && !lat_err) port_wr = port_sel;
      end
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_write <= 1'b0;
      lat_port  <= '0;
      lat_reg   <= '0;
      lat_wdata <= '0;
      lat_err   <= 1'b0;
      wait_cnt  <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      port_sel  <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        for (int r = 0; r < REGS_PER_PORT; r++) begin
          regs[p][r] <= '0;
        end
      end
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_write <= req_write;
            lat_port  <= dec_port;
            lat_reg   <= dec_reg;
            lat_wdata <= req_wdata;
            lat_err   <= dec_err;
            port_sel  <= dec_err ? '0 : ({{(NUM_PORTS-1){1'b0}}, 1'b1} << dec_port);
            wait_cnt  <= (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
          end
        end
        WAIT: begin
          if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
        end
        COMMIT: begin
          rsp_valid <= 1'b1;
          rsp_rdata <= '0;
          if (lat_err) begin
            rsp_err <= 1'b1;
          end else if (lat_write) begin
            regs[lat_port][lat_reg] <= lat_wdata;
          end else begin
            rsp_rdata <= regs[lat_port][lat_reg];
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            port_sel  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_periph_bus_ctrl.sv
// Directed bench for periph_bus_ctrl: three instances with WAIT_CYCLES = 1, 0 and 3
// driven from a vector table plus hand-written backpressure, reset and sweep sequences.
module tb_periph_bus_ctrl;

  localparam int NI = 3;

  function automatic int wc(input int k);
    return (k == 0) ? 1 : (k == 1) ? 0 : 3;
  endfunction

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid [NI];
  logic        req_write [NI];
  logic [31:0] req_addr  [NI];
  logic [31:0] req_wdata [NI];
  logic        req_ready [NI];
  logic        rsp_valid [NI];
  logic        rsp_ready [NI];
  logic [31:0] rsp_rdata [NI];
  logic        rsp_err   [NI];
  logic [3:0]  port_sel  [NI];
  logic [3:0]  port_wr   [NI];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      periph_bus_ctrl #(
        .DATA_W(32), .ADDR_W(32), .NUM_PORTS(4), .REGS_PER_PORT(4), .WAIT_CYCLES(wc(g))
      ) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[g]), .req_write(req_write[g]), .req_addr(req_addr[g]),
        .req_wdata(req_wdata[g]), .req_ready(req_ready[g]),
        .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]), .rsp_rdata(rsp_rdata[g]),
        .rsp_err(rsp_err[g]), .port_sel(port_sel[g]), .port_wr(port_wr[g])
      );
    end
  endgenerate

  // port_wr pulse monitor: count of high cycles and last non-zero value
  int         pw_cnt [NI];
  logic [3:0] pw_val [NI];
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (port_wr[k] != 4'b0) begin
        pw_cnt[k] <= pw_cnt[k] + 1;
        pw_val[k] <= port_wr[k];
      end
    end
  end

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic access(input int k, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic err, output logic [3:0] psel,
                        output int pw_delta, output logic [3:0] pw_v, output int acc_cyc);
    int tmo;
    int c0;
    rdata = '0; err = 1'b0; psel = '0; pw_delta = 0; pw_v = '0; acc_cyc = 0;
    c0  = pw_cnt[k];
    tmo = 0;
    @(negedge clk);
    while (req_ready[k] !== 1'b1 && tmo < 50) begin
      tmo++;
      @(negedge clk);
    end
    check("req_ready_timeout", 32'(tmo >= 50), 32'd0);
    if (tmo >= 50) return;
    req_valid[k] = 1'b1;
    req_write[k] = wr;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    @(posedge clk);
    #1;
    acc_cyc      = cyc;
    req_valid[k] = 1'b0;
    tmo = 0;
    @(negedge clk);
    while (rsp_valid[k] !== 1'b1 && tmo < 50) begin
      tmo++;
      @(negedge clk);
    end
    check("rsp_valid_timeout", 32'(tmo >= 50), 32'd0);
    if (tmo >= 50) return;
    rdata    = rsp_rdata[k];
    err      = rsp_err[k];
    psel     = port_sel[k];
    pw_delta = pw_cnt[k] - c0;
    pw_v     = pw_val[k];
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [3:0]  exp_psel;
    logic [3:0]  exp_pw;
  } vec_t;

  vec_t vecs [16];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [3:0]  ps;
    logic [3:0]  pv;
    int          pd;
    int          ac;
    int          prev_ac;
    int          c0;
    int          bad;
    logic [31:0] a;
    logic [31:0] v;

    vecs[0]  = '{1'b0, 32'h8000_0004, 32'h0,         32'h0,         1'b0, 4'b0100, 4'b0000};
    vecs[1]  = '{1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0,         1'b0, 4'b0100, 4'b0100};
    vecs[2]  = '{1'b0, 32'h8000_0004, 32'h0,         32'hDEAD_BEEF, 1'b0, 4'b0100, 4'b0000};
    vecs[3]  = '{1'b1, 32'h4000_0002, 32'h1111_1111, 32'h0,         1'b1, 4'b0000, 4'b0000};
    vecs[4]  = '{1'b1, 32'h4000_0100, 32'h2222_2222, 32'h0,         1'b1, 4'b0000, 4'b0000};
    vecs[5]  = '{1'b0, 32'h4000_0000, 32'h0,         32'h0,         1'b0, 4'b0010, 4'b0000};
    vecs[6]  = '{1'b1, 32'h4000_0000, 32'h1234_5678, 32'h0,         1'b0, 4'b0010, 4'b0010};
    vecs[7]  = '{1'b0, 32'h4000_0002, 32'h0,         32'h0,         1'b1, 4'b0000, 4'b0000};
    vecs[8]  = '{1'b0, 32'h4000_0000, 32'h0,         32'h1234_5678, 1'b0, 4'b0010, 4'b0000};
    vecs[9]  = '{1'b1, 32'hC000_000C, 32'hA5A5_5A5A, 32'h0,         1'b0, 4'b1000, 4'b1000};
    vecs[10] = '{1'b0, 32'hC000_000C, 32'h0,         32'hA5A5_5A5A, 1'b0, 4'b1000, 4'b0000};
    vecs[11] = '{1'b0, 32'h0000_0010, 32'h0,         32'h0,         1'b1, 4'b0000, 4'b0000};
    vecs[12] = '{1'b0, 32'h8000_000C, 32'h0,         32'h0,         1'b0, 4'b0100, 4'b0000};
    vecs[13] = '{1'b0, 32'h8000_0004, 32'h0,         32'hDEAD_BEEF, 1'b0, 4'b0100, 4'b0000};
    vecs[14] = '{1'b1, 32'h0000_0008, 32'h0F0F_0F0F, 32'h0,         1'b0, 4'b0001, 4'b0001};
    vecs[15] = '{1'b0, 32'h0000_0008, 32'h0,         32'h0F0F_0F0F, 1'b0, 4'b0001, 4'b0000};

    // clock/reset
    reset = 1'b1;
    for (int k = 0; k < NI; k++) begin
      req_valid[k] = 1'b0; req_write[k] = 1'b0; req_addr[k] = '0; req_wdata[k] = '0;
      rsp_ready[k] = 1'b1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("rst_req_ready%0d", k), 32'(req_ready[k]), 32'd1);
      check($sformatf("rst_rsp_valid%0d", k), 32'(rsp_valid[k]), 32'd0);
      check($sformatf("rst_port_sel%0d", k),  32'(port_sel[k]),  32'd0);
      check($sformatf("rst_port_wr%0d", k),   32'(port_wr[k]),   32'd0);
      check($sformatf("rst_rsp_rdata%0d", k), rsp_rdata[k],      32'd0);
      check($sformatf("rst_rsp_err%0d", k),   32'(rsp_err[k]),   32'd0);
    end
    reset = 1'b0;

    // every register reads 0 after reset
    for (int p = 0; p < 4; p++) begin
      for (int r = 0; r < 4; r++) begin
        a = {p[1:0], 26'b0, r[1:0], 2'b00};
        access(0, 1'b0, a, 32'h0, rd, er, ps, pd, pv, ac);
        check($sformatf("rst_read_p%0d_r%0d", p, r), rd, 32'h0);
        check($sformatf("rst_read_err_p%0d_r%0d", p, r), 32'(er), 32'd0);
      end
    end

    // vector table on the WAIT_CYCLES=1 instance
    for (int i = 0; i < 16; i++) begin
      access(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er, ps, pd, pv, ac);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_port_sel", i), 32'(ps), 32'(vecs[i].exp_psel));
      check($sformatf("vec%0d_port_wr_pulses", i), 32'(pd), 32'(vecs[i].exp_pw != 4'b0));
      if (pd == 1) check($sformatf("vec%0d_port_wr", i), 32'(pv), 32'(vecs[i].exp_pw));
    end

    // response backpressure with a second request ignored
    c0 = pw_cnt[0];
    @(negedge clk);
    rsp_ready[0] = 1'b0;
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 32'h8000_0004;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    for (int n = 1; n <= wc(0) + 3; n++) begin
      @(negedge clk);
      if (n == wc(0) + 1) check("lat_rsp_valid_early", 32'(rsp_valid[0]), 32'd0);
    end
    check("lat_rsp_valid", 32'(rsp_valid[0]), 32'd1);
    check("lat_rsp_rdata", rsp_rdata[0], 32'hDEAD_BEEF);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h8000_0004;
    req_wdata[0] = 32'hBAD0_BAD0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check($sformatf("bp_rsp_valid%0d", n), 32'(rsp_valid[0]), 32'd1);
      check($sformatf("bp_rsp_rdata%0d", n), rsp_rdata[0], 32'hDEAD_BEEF);
      check($sformatf("bp_req_ready%0d", n), 32'(req_ready[0]), 32'd0);
    end
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check("bp_release_req_ready", 32'(req_ready[0]), 32'd1);
    check("bp_no_port_wr", 32'(pw_cnt[0] - c0), 32'd0);
    access(0, 1'b0, 32'h8000_0004, 32'h0, rd, er, ps, pd, pv, ac);
    check("bp_reg_unchanged", rd, 32'hDEAD_BEEF);

    // reset during WAIT of a write to port3 reg0 (WAIT_CYCLES=3 instance)
    c0 = pw_cnt[2];
    @(negedge clk);
    req_valid[2] = 1'b1; req_write[2] = 1'b1; req_addr[2] = 32'hC000_0000;
    req_wdata[2] = 32'h55AA_55AA;
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (rsp_valid[2] !== 1'b0 || port_wr[2] !== 4'b0) bad++;
    end
    check("rstw_no_response", 32'(bad), 32'd0);
    check("rstw_no_port_wr", 32'(pw_cnt[2] - c0), 32'd0);
    access(2, 1'b0, 32'hC000_0000, 32'h0, rd, er, ps, pd, pv, ac);
    check("rstw_reg_zero", rd, 32'h0);
    access(0, 1'b0, 32'h8000_0004, 32'h0, rd, er, ps, pd, pv, ac);
    check("rstw_other_reg_cleared", rd, 32'h0);

    // back-to-back sweep of all 16 registers on each instance
    for (int k = 0; k < NI; k++) begin
      prev_ac = 0;
      for (int p = 0; p < 4; p++) begin
        for (int r = 0; r < 4; r++) begin
          a = {p[1:0], 26'b0, r[1:0], 2'b00};
          v = {8'(k + 1), 8'(p), 8'(r), 8'hA5} ^ 32'h3C5A_0000;
          access(k, 1'b1, a, v, rd, er, ps, pd, pv, ac);
          exp_q.push_back(v);
          check($sformatf("sw%0d_wr_err_p%0d_r%0d", k, p, r), 32'(er), 32'd0);
          if (p != 0 || r != 0)
            check($sformatf("sw%0d_period_p%0d_r%0d", k, p, r), 32'(ac - prev_ac), 32'(wc(k) + 3));
          prev_ac = ac;
        end
      end
      for (int p = 0; p < 4; p++) begin
        for (int r = 0; r < 4; r++) begin
          a = {p[1:0], 26'b0, r[1:0], 2'b00};
          access(k, 1'b0, a, 32'h0, rd, er, ps, pd, pv, ac);
          check($sformatf("sw%0d_rd_p%0d_r%0d", k, p, r), rd, exp_q.pop_front());
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
